double_dabble_arbiter: RTL



---
 rtl/double_dabble_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/double_dabble_arbiter.sv
// double_dabble_arbiter: shares one pipelined binary-to-BCD converter between Requesters channels, tagging each issue.
// Latency: handshake at T -> dd_bin_valid at T+1 -> FIFO write at T+1+Converter_Latency -> rsp_valid at T+2+Converter_Latency.
// Backpressure: rsp_ready never stalls the converter; grants stop while tag pipe + FIFO already hold Fifo_Depth results.
// Build option: define DD_ARB_STRICT_PRIORITY_EN for fixed lowest-index-wins priority (no round-robin pointer).
module double_dabble_arbiter #(
  parameter int Input_Bit_Width   = 8,
  parameter int Requesters        = 4,
  parameter int Converter_Latency = 3,
  parameter int Fifo_Depth        = 4,
  parameter int Total_Nibbles     = (Input_Bit_Width / 3) + 1
) (
  input  logic                                  clk,
  input  logic                                  clk_en,
  input  logic                                  sync_rst,
  input  logic [Requesters-1:0]                 req_valid,
  input  logic [Requesters*Input_Bit_Width-1:0] req_data,
  output logic [Requesters-1:0]                 req_ready,
  output logic [Input_Bit_Width-1:0]            dd_bin,
  output logic                                  dd_bin_valid,
  input  logic [Total_Nibbles*4-1:0]            dd_nibbles_in,
  input  logic [Total_Nibbles-1:0]              dd_digit_valid_in,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [$clog2(Requesters)-1:0]         rsp_id,
  output logic [Total_Nibbles*4-1:0]            rsp_nibbles,
  output logic [Total_Nibbles-1:0]              rsp_digit_valid
);

  localparam int IdW  = $clog2(Requesters);
  localparam int Aw   = $clog2(Fifo_Depth);
  localparam int CrW  = $clog2(Fifo_Depth + 1);
  localparam int EntW = IdW + Total_Nibbles * 5;

  logic [CrW-1:0]             credits_used;
  logic                       credit_ok;
  logic                       grant_vld;
  logic [IdW-1:0]             grant_id;
  logic [Input_Bit_Width-1:0] grant_dat;
  int                         scan_int;

  logic [IdW-1:0]               issue_id;
  logic [Converter_Latency-1:0] pipe_vld;
  logic [IdW-1:0]               pipe_id [Converter_Latency];

  logic [EntW-1:0] fifo_mem [Fifo_Depth];
  logic [Aw:0]     wr_ptr;
  logic [Aw:0]     rd_ptr;
  logic            push;
  logic            pop;

  // Credits cover every result already issued but not yet popped, so the FIFO cannot overflow.
  assign credit_ok = (credits_used < CrW'(Fifo_Depth));

`ifdef DD_ARB_STRICT_PRIORITY_EN
  // Fixed priority: lowest requesting index wins, no pointer state.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_int  = 0;
    if (clk_en && credit_ok && !sync_rst) begin
      for (int i = 0; i < Requesters; i++) begin
        scan_int = i;
        for (int j = 0; j < Requesters; j++) begin
          if (!grant_vld && scan_int == j && req_valid[j]) begin
            grant_vld = 1'b1;
            grant_id  = IdW'(j);
          end
        end
      end
    end
  end
`else
  logic [IdW-1:0] rr_ptr;

  // Round-robin: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_int  = 0;
    if (clk_en && credit_ok && !sync_rst) begin
      for (int i = 0; i < Requesters; i++) begin
        scan_int = (int'(rr_ptr) + i) % Requesters;
        for (int j = 0; j < Requesters; j++) begin
          if (!grant_vld && scan_int == j && req_valid[j]) begin
            grant_vld = 1'b1;
            grant_id  = IdW'(j);
          end
        end
      end
    end
  end

  // Move the pointer just past each granted index; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_id == IdW'(Requesters - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`endif

  // Decode the grant into the one-hot ready vector and select the granted operand.
  always_comb begin
    req_ready = '0;
    grant_dat = '0;
    for (int j = 0; j < Requesters; j++) begin
      if (grant_vld && grant_id == IdW'(j)) begin
        req_ready[j] = 1'b1;
        grant_dat    = req_data[j*Input_Bit_Width +: Input_Bit_Width];
      end
    end
  end

  // Issue register feeding the converter; the tag rides alongside dd_bin_valid.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      dd_bin       <= '0;
      dd_bin_valid <= 1'b0;
      issue_id     <= '0;
    end else if (clk_en) begin
      dd_bin_valid <= grant_vld;
      if (grant_vld) begin
        dd_bin   <= grant_dat;
        issue_id <= grant_id;
      end
    end
  end

  // Shadow tag pipe matching the converter depth; its last stage marks a valid converter result.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < Converter_Latency; k++) pipe_id[k] <= '0;
    end else if (clk_en) begin
      pipe_vld[0] <= dd_bin_valid;
      pipe_id[0]  <= issue_id;
      for (int k = 1; k < Converter_Latency; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  assign push      = clk_en && pipe_vld[Converter_Latency-1];
  assign pop       = clk_en && rsp_valid && rsp_ready;
  assign rsp_valid = (wr_ptr != rd_ptr);
  assign {rsp_id, rsp_nibbles, rsp_digit_valid} = fifo_mem[rd_ptr[Aw-1:0]];

  // Result FIFO: registered head, no fall-through; pointers carry an extra wrap bit.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int e = 0; e < Fifo_Depth; e++) fifo_mem[e] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[Aw-1:0]] <= {pipe_id[Converter_Latency-1], dd_nibbles_in, dd_digit_valid_in};
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Credit counter: +1 per grant, -1 per pop, unchanged when both happen together.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      credits_used <= '0;
    end else if (grant_vld && !pop) begin
      credits_used <= credits_used + 1'b1;
    end else if (!grant_vld && pop) begin
      credits_used <= credits_used - 1'b1;
    end
  end

endmodule
